// File: rtl/sprite_palette_encoder_if.sv
// Pixel-in / index-out / palette-write bus of the sprite palette encoder.
// slave is the encoder side, master is the pixel source / palette loader side.
interface sprite_palette_encoder_if #(
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned COLOR_W = 24,
    parameter int unsigned DIST_W  = 10
);
    logic               i_pal_we;
    logic [IDX_W-1:0]   i_pal_addr;
    logic [COLOR_W-1:0] i_pal_data;
    logic               o_pal_ready;
    logic               i_in_valid;
    logic               o_in_ready;
    logic [COLOR_W-1:0] i_in_rgb;
    logic               i_in_transp;
    logic               o_out_valid;
    logic               i_out_ready;
    logic [IDX_W-1:0]   o_out_idx;
    logic [DIST_W-1:0]  o_out_dist;

    modport slave (
        input  i_pal_we, i_pal_addr, i_pal_data, i_in_valid, i_in_rgb, i_in_transp, i_out_ready,
        output o_pal_ready, o_in_ready, o_out_valid, o_out_idx, o_out_dist
    );

    modport master (
        output i_pal_we, i_pal_addr, i_pal_data, i_in_valid, i_in_rgb, i_in_transp, i_out_ready,
        input  o_pal_ready, o_in_ready, o_out_valid, o_out_idx, o_out_dist
    );
endinterface

// File: rtl/sprite_palette_encoder.sv
// Quantises RGB888 pixels to 4-bit indices by a sequential nearest-colour search
// over palette entries 1..15. Define PALETTE_EARLY_EXIT_EN to stop on an exact match.
module sprite_palette_encoder (
    input  logic                     i_clk,
    input  logic                     i_rst,
    sprite_palette_encoder_if.slave  bus
);
    localparam int unsigned N_ENTRIES = 16;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned COLOR_W   = 24;
    localparam int unsigned DIST_W    = 10;
    localparam int unsigned CH_W      = 8;

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_OUT} state_e;

    state_e             state_q;
    logic [COLOR_W-1:0] pal_q [N_ENTRIES];
    logic [COLOR_W-1:0] rgb_q;
    logic [IDX_W-1:0]   k_q;
    logic [IDX_W-1:0]   best_idx_q;
    logic [DIST_W-1:0]  best_dist_q;
    logic               ready_q;
    logic               out_valid_q;
    logic [IDX_W-1:0]   out_idx_q;
    logic [DIST_W-1:0]  out_dist_q;

    logic [COLOR_W-1:0] entry_c;
    logic [DIST_W-1:0]  dist_c;
    logic               better_c;
    logic               last_c;

    function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] a, input logic [CH_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Manhattan distance between the latched pixel and the entry under test
    always_comb begin
        entry_c  = pal_q[k_q];
        dist_c   = DIST_W'(abs_diff(rgb_q[23:16], entry_c[23:16]))
                 + DIST_W'(abs_diff(rgb_q[15:8],  entry_c[15:8]))
                 + DIST_W'(abs_diff(rgb_q[7:0],   entry_c[7:0]));
        better_c = (dist_c < best_dist_q);
`ifdef PALETTE_EARLY_EXIT_EN
        last_c   = (k_q == IDX_W'(N_ENTRIES - 1)) || (dist_c == '0);
`else
        last_c   = (k_q == IDX_W'(N_ENTRIES - 1));
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < int'(N_ENTRIES); i++) pal_q[i] <= '0;
            rgb_q       <= '0;
            k_q         <= IDX_W'(1);
            best_idx_q  <= IDX_W'(1);
            best_dist_q <= '1;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_dist_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // write lands on this edge, so a search starting now sees it
                    if (bus.i_pal_we) pal_q[bus.i_pal_addr] <= bus.i_pal_data;
                    if (bus.i_in_valid) begin
                        rgb_q   <= bus.i_in_rgb;
                        ready_q <= 1'b0;
                        if (bus.i_in_transp) begin
                            state_q     <= S_OUT;
                            out_valid_q <= 1'b1;
                            out_idx_q   <= '0;
                            out_dist_q  <= '0;
                        end else begin
                            state_q     <= S_SEARCH;
                            k_q         <= IDX_W'(1);
                            best_idx_q  <= IDX_W'(1);
                            best_dist_q <= '1;
                        end
                    end
                end
                S_SEARCH: begin
                    if (better_c) begin
                        best_idx_q  <= k_q;
                        best_dist_q <= dist_c;
                    end
                    if (last_c) begin
                        state_q     <= S_OUT;
                        out_valid_q <= 1'b1;
                        out_idx_q   <= better_c ? k_q    : best_idx_q;
                        out_dist_q  <= better_c ? dist_c : best_dist_q;
                    end else begin
                        k_q <= k_q + IDX_W'(1);
                    end
                end
                S_OUT: begin
                    if (bus.i_out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_in_ready  = ready_q;
    assign bus.o_pal_ready = ready_q;
    assign bus.o_out_valid = out_valid_q;
    assign bus.o_out_idx   = out_idx_q;
    assign bus.o_out_dist  = out_dist_q;
endmodule

// File: tb/tb_sprite_palette_encoder.sv
// Directed bench for sprite_palette_encoder; latency expectations follow
// PALETTE_EARLY_EXIT_EN when it is defined for the build.
module tb_sprite_palette_encoder;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    logic [23:0] pal_tab [16];
    int   lat;
    logic [3:0]  got_idx;
    logic [9:0]  got_dist;

    sprite_palette_encoder_if bus ();

    sprite_palette_encoder dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_exact(input int k);
`ifdef PALETTE_EARLY_EXIT_EN
        return k + 1;
`else
        return (k > 0) ? 16 : 16;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // All tasks start and end just after a negedge.
    task automatic pal_write(input logic [3:0] addr, input logic [23:0] data);
        bus.i_pal_we   = 1'b1;
        bus.i_pal_addr = addr;
        bus.i_pal_data = data;
        @(posedge clk); @(negedge clk);
        bus.i_pal_we   = 1'b0;
    endtask

    task automatic load_palette();
        for (int i = 1; i < 16; i++) pal_write(4'(i), pal_tab[i]);
    endtask

    task automatic accept(input logic [23:0] rgb, input logic transp,
                          input logic we, input logic [3:0] addr, input logic [23:0] data);
        bus.i_in_valid  = 1'b1;
        bus.i_in_rgb    = rgb;
        bus.i_in_transp = transp;
        bus.i_pal_we    = we;
        bus.i_pal_addr  = addr;
        bus.i_pal_data  = data;
        @(posedge clk); @(negedge clk);
        bus.i_in_valid  = 1'b0;
        bus.i_pal_we    = 1'b0;
    endtask

    task automatic wait_valid(output int l);
        l = 1;
        while (bus.o_out_valid !== 1'b1 && l < 40) begin
            @(posedge clk); @(negedge clk);
            l++;
        end
        got_idx  = bus.o_out_idx;
        got_dist = bus.o_out_dist;
    endtask

    task automatic ack(input string tag);
        bus.i_out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.i_out_ready = 1'b0;
        check({tag, "_in_ready_after_ack"}, 32'(bus.o_in_ready), 32'd1);
        check({tag, "_valid_after_ack"}, 32'(bus.o_out_valid), 32'd0);
    endtask

    task automatic send(input string tag, input logic [23:0] rgb, input logic transp,
                        input int exp_idx, input int exp_dist, input int exp_lat);
        accept(rgb, transp, 1'b0, 4'd0, 24'd0);
        wait_valid(lat);
        check({tag, "_idx"},  32'(got_idx),  32'(exp_idx));
        check({tag, "_dist"}, 32'(got_dist), 32'(exp_dist));
        check({tag, "_lat"},  32'(lat),      32'(exp_lat));
        ack(tag);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        pal_tab[0]  = 24'h000000; pal_tab[1]  = 24'hffffff; pal_tab[2]  = 24'h7fffff;
        pal_tab[3]  = 24'h8dfe8d; pal_tab[4]  = 24'h77dbbd; pal_tab[5]  = 24'h00ffff;
        pal_tab[6]  = 24'h72ccbb; pal_tab[7]  = 24'h71c6c2; pal_tab[8]  = 24'h75c1c3;
        pal_tab[9]  = 24'h72c0c8; pal_tab[10] = 24'h64c3bc; pal_tab[11] = 24'h5ebec0;
        pal_tab[12] = 24'h4db9be; pal_tab[13] = 24'h57aca9; pal_tab[14] = 24'h7f7f7f;
        pal_tab[15] = 24'h000000;

        rst = 1'b1;
        bus.i_pal_we = 1'b0; bus.i_pal_addr = '0; bus.i_pal_data = '0;
        bus.i_in_valid = 1'b0; bus.i_in_rgb = '0; bus.i_in_transp = 1'b0;
        bus.i_out_ready = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_in_ready",  32'(bus.o_in_ready),  32'd1);
        check("rst_pal_ready", 32'(bus.o_pal_ready), 32'd1);
        check("rst_out_valid", 32'(bus.o_out_valid), 32'd0);
        check("rst_out_idx",   32'(bus.o_out_idx),   32'd0);
        check("rst_out_dist",  32'(bus.o_out_dist),  32'd0);
        rst = 1'b0;

        load_palette();
        send("exact",   24'h00ffff, 1'b0, 5, 0, lat_exact(5));
        send("near_a",  24'h01fefe, 1'b0, 5, 3, 16);
        send("near_b",  24'h808080, 1'b0, 14, 3, 16);
        send("black",   24'h000000, 1'b0, 15, 0, lat_exact(15));
        pal_write(4'd2, 24'hffffff);
        send("tie",     24'hffffff, 1'b0, 1, 0, lat_exact(1));

        // write and pixel in the same IDLE cycle: search must see the new entry 3
        load_palette();
        accept(24'habcdef, 1'b0, 1'b1, 4'd3, 24'habcdef);
        wait_valid(lat);
        check("samecyc_idx",  32'(got_idx),  32'd3);
        check("samecyc_dist", 32'(got_dist), 32'd0);
        check("samecyc_lat",  32'(lat),      32'(lat_exact(3)));
        ack("samecyc");

        load_palette();
        send("transp_a", 24'h123456, 1'b1, 0, 0, 1);
        send("transp_b", 24'h00ffff, 1'b1, 0, 0, 1);

        // backpressure with a palette write attempted throughout the busy period
        load_palette();
        accept(24'h00ffff, 1'b0, 1'b0, 4'd0, 24'd0);
        check("busy_pal_ready", 32'(bus.o_pal_ready), 32'd0);
        bus.i_pal_we = 1'b1; bus.i_pal_addr = 4'd5; bus.i_pal_data = 24'h123456;
        wait_valid(lat);
        bus.i_pal_we = 1'b0;
        check("bp_idx", 32'(got_idx), 32'd5);
        check("bp_lat", 32'(lat), 32'(lat_exact(5)));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); @(negedge clk);
            check("bp_hold_valid",    32'(bus.o_out_valid), 32'd1);
            check("bp_hold_idx",      32'(bus.o_out_idx),   32'd5);
            check("bp_hold_dist",     32'(bus.o_out_dist),  32'd0);
            check("bp_hold_in_ready", 32'(bus.o_in_ready),  32'd0);
        end
        ack("bp");
        send("bp_rerun", 24'h00ffff, 1'b0, 5, 0, lat_exact(5));

        // reset in cycle T+7 of a search
        accept(24'h00ffff, 1'b0, 1'b0, 4'd0, 24'd0);
        repeat (6) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("midrst_valid",    32'(bus.o_out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.o_in_ready),  32'd1);
        check("midrst_idx",      32'(bus.o_out_idx),   32'd0);
        send("cleared_a", 24'h00ffff, 1'b0, 1, 510, 16);
        send("cleared_b", 24'h000000, 1'b0, 1, 0, lat_exact(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
